// File: rtl/lfsr_box_picker.sv
// -----------------------------------------------------------------------------
// lfsr_box_picker
//
// Random box selector for the ByteBasher game logic. A WIDTH-bit maximal-length
// Fibonacci LFSR supplies candidates to a rejection-sampling draw engine. Each
// draw returns a uniformly distributed box index in 0..NUM_BOXES-1 through a
// req/valid handshake. With NO_REPEAT=1 the delivered box never equals the one
// delivered just before it. If MAX_TRIES candidates in a row are rejected, the
// engine falls back to a deterministic choice and flags it. The LFSR can be
// reseeded from a free-running entropy counter.
//
// Parameters:
//   WIDTH      LFSR / entropy counter width, 3..16, and at least BOX_W+1
//   NUM_BOXES  number of selectable boxes, 2..16
//   NO_REPEAT  1: a delivered box must differ from the previous delivered box
//   MAX_TRIES  rejected candidates allowed before the fallback path, >= 1
//   BOX_W      width of the box index, clog2(NUM_BOXES)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   enable    in   LFSR step enable (also gates candidate evaluation)
//   reseed    in   single-cycle reseed command; aborts a draw in progress
//   req       in   draw request, sampled only while idle
//   busy      out  high while a draw is in progress
//   valid     out  one-cycle pulse marking a new result on box/fallback
//   box       out  drawn index, held until the next valid
//   fallback  out  result came from the fallback path, held with box
// -----------------------------------------------------------------------------
module lfsr_box_picker #(
    parameter int  WIDTH     = 8,
    parameter int  NUM_BOXES = 4,
    parameter int  NO_REPEAT = 1,
    parameter int  MAX_TRIES = 16,
    localparam int BOX_W     = $clog2(NUM_BOXES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             reseed,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [BOX_W-1:0] box,
    output logic             fallback
);

    // Feedback tap masks: tap n selects lfsr[n-1]. Each entry gives a
    // maximal-length sequence for its width.
    function automatic logic [WIDTH-1:0] tap_mask(input int w);
        logic [15:0] m;
        case (w)
            3:       m = 16'h0006;  // 3,2
            4:       m = 16'h000C;  // 4,3
            5:       m = 16'h0014;  // 5,3
            6:       m = 16'h0030;  // 6,5
            7:       m = 16'h0060;  // 7,6
            8:       m = 16'h00B8;  // 8,6,5,4
            9:       m = 16'h0110;  // 9,5
            10:      m = 16'h0240;  // 10,7
            11:      m = 16'h0500;  // 11,9
            12:      m = 16'h0E08;  // 12,11,10,4
            13:      m = 16'h1C80;  // 13,12,11,8
            14:      m = 16'h3802;  // 14,13,12,2
            15:      m = 16'h6000;  // 15,14
            16:      m = 16'hD008;  // 16,15,13,4
            default: m = 16'h0000;
        endcase
        return WIDTH'(m);
    endfunction

    localparam logic [WIDTH-1:0] TAP_MASK = tap_mask(WIDTH);

    // Tries counter must hold values up to MAX_TRIES-1.
    localparam int               TRY_W       = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] LAST_TRY    = TRY_W'(MAX_TRIES - 1);
    localparam logic [BOX_W:0]   NUM_BOXES_W = (BOX_W + 1)'(NUM_BOXES);
    localparam logic [BOX_W-1:0] LAST_BOX    = BOX_W'(NUM_BOXES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] lfsr_reg, lfsr_next;
    logic [WIDTH-1:0] cnt_reg;
    state_t           state_reg, state_next;
    logic [TRY_W-1:0] tries_reg, tries_next;
    logic [BOX_W-1:0] box_reg, box_next;
    logic             valid_reg, valid_next;
    logic             fallback_reg, fallback_next;
    logic             delivered_reg, delivered_next;

    // -------------------------------------------------------------------------
    // LFSR feedback
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] tap_terms;
    logic             fb;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_terms[gi] = lfsr_reg[gi] & TAP_MASK[gi];
        end
    endgenerate

    assign fb = ^tap_terms;

    // Reseed has priority over stepping. A zero counter would lock the LFSR,
    // so it is replaced by 1.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (reseed) begin
            lfsr_next = (cnt_reg == '0) ? WIDTH'(1) : cnt_reg;
        end else if (enable) begin
            lfsr_next = {lfsr_reg[WIDTH-2:0], fb};
        end
    end

    // -------------------------------------------------------------------------
    // Candidate evaluation
    // -------------------------------------------------------------------------
    logic [BOX_W-1:0] candidate;
    logic             in_range;
    logic             not_repeat;
    logic             accept;
    logic [BOX_W-1:0] fallback_box;

    assign candidate = lfsr_reg[BOX_W-1:0];

    // Widened compare so NUM_BOXES = 2**BOX_W is representable.
    assign in_range = ({1'b0, candidate} < NUM_BOXES_W);

    // Before the first delivery there is no previous box to avoid.
    assign not_repeat = (NO_REPEAT == 0) || !delivered_reg || (candidate != box_reg);

    assign accept = in_range && not_repeat;

    // Fallback walks to the next box (which always differs from the previous
    // one, so no-repeat still holds), or starts at 0 if nothing was delivered.
    always_comb begin
        fallback_box = '0;
        if (delivered_reg && (box_reg != LAST_BOX)) begin
            fallback_box = box_reg + BOX_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Draw FSM: next state and result registers
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        tries_next     = tries_reg;
        box_next       = box_reg;
        valid_next     = 1'b0;
        fallback_next  = fallback_reg;
        delivered_next = delivered_reg;

        case (state_reg)
            ST_IDLE: begin
                // A simultaneous reseed wins and the request is dropped.
                if (req && !reseed) begin
                    state_next = ST_DRAW;
                    tries_next = '0;
                end
            end

            ST_DRAW: begin
                if (reseed) begin
                    // Abort: no result, box left as it was.
                    state_next = ST_IDLE;
                end else if (enable) begin
                    if (accept) begin
                        box_next       = candidate;
                        valid_next     = 1'b1;
                        fallback_next  = 1'b0;
                        delivered_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else if (tries_reg == LAST_TRY) begin
                        box_next       = fallback_box;
                        valid_next     = 1'b1;
                        fallback_next  = 1'b1;
                        delivered_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        tries_next = tries_reg + TRY_W'(1);
                    end
                end
                // enable=0: stall with everything frozen.
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg      <= WIDTH'(1);
            cnt_reg       <= '0;
            state_reg     <= ST_IDLE;
            tries_reg     <= '0;
            box_reg       <= '0;
            valid_reg     <= 1'b0;
            fallback_reg  <= 1'b0;
            delivered_reg <= 1'b0;
        end else begin
            lfsr_reg      <= lfsr_next;
            cnt_reg       <= cnt_reg + WIDTH'(1);
            state_reg     <= state_next;
            tries_reg     <= tries_next;
            box_reg       <= box_next;
            valid_reg     <= valid_next;
            fallback_reg  <= fallback_next;
            delivered_reg <= delivered_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy     = (state_reg == ST_DRAW);
    assign valid    = valid_reg;
    assign box      = box_reg;
    assign fallback = fallback_reg;

endmodule

// File: tb/tb_lfsr_box_picker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_box_picker
//
// Five instances with different NUM_BOXES / NO_REPEAT / MAX_TRIES share one set
// of inputs. Directed scenarios check the documented cycle-exact behaviour;
// randomized traffic is checked against a transaction-level reference model
// that predicts each draw's result from the LFSR value at draw start.
// -----------------------------------------------------------------------------
module tb_lfsr_box_picker;

    logic clk;
    logic reset;
    logic enable;
    logic reseed;
    logic req;

    logic       busy_v     [5];
    logic       valid_v    [5];
    logic       fallback_v [5];
    logic [1:0] box0, box1, box2;
    logic [0:0] box3, box4;
    int         box_v      [5];

    int errors = 0;
    int checks = 0;

    localparam int N_T  [5] = '{4, 3, 3, 2, 2};
    localparam int NR_T [5] = '{1, 1, 1, 1, 0};
    localparam int MT_T [5] = '{16, 16, 1, 16, 16};

    lfsr_box_picker #(.WIDTH(8), .NUM_BOXES(4), .NO_REPEAT(1), .MAX_TRIES(16)) u_d0 (
        .clk(clk), .reset(reset), .enable(enable), .reseed(reseed), .req(req),
        .busy(busy_v[0]), .valid(valid_v[0]), .box(box0), .fallback(fallback_v[0]));
    lfsr_box_picker #(.WIDTH(8), .NUM_BOXES(3), .NO_REPEAT(1), .MAX_TRIES(16)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .reseed(reseed), .req(req),
        .busy(busy_v[1]), .valid(valid_v[1]), .box(box1), .fallback(fallback_v[1]));
    lfsr_box_picker #(.WIDTH(8), .NUM_BOXES(3), .NO_REPEAT(1), .MAX_TRIES(1)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .reseed(reseed), .req(req),
        .busy(busy_v[2]), .valid(valid_v[2]), .box(box2), .fallback(fallback_v[2]));
    lfsr_box_picker #(.WIDTH(8), .NUM_BOXES(2), .NO_REPEAT(1), .MAX_TRIES(16)) u_d3 (
        .clk(clk), .reset(reset), .enable(enable), .reseed(reseed), .req(req),
        .busy(busy_v[3]), .valid(valid_v[3]), .box(box3), .fallback(fallback_v[3]));
    lfsr_box_picker #(.WIDTH(8), .NUM_BOXES(2), .NO_REPEAT(0), .MAX_TRIES(16)) u_d4 (
        .clk(clk), .reset(reset), .enable(enable), .reseed(reseed), .req(req),
        .busy(busy_v[4]), .valid(valid_v[4]), .box(box4), .fallback(fallback_v[4]));

    always_comb begin
        box_v[0] = int'(box0);
        box_v[1] = int'(box1);
        box_v[2] = int'(box2);
        box_v[3] = int'(box3);
        box_v[4] = int'(box4);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Reference: 8-bit LFSR with taps 8,6,5,4 and its reseed/counter rules
    // ---------------------------------------------------------------------
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [7:0] m_lfsr;
    logic [7:0] m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= 8'd1;
            m_cnt  <= 8'd0;
        end else begin
            m_cnt <= m_cnt + 8'd1;
            if (reseed)      m_lfsr <= (m_cnt == 8'd0) ? 8'd1 : m_cnt;
            else if (enable) m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    // Outcome of one draw for instance i, given the LFSR at the first draw
    // cycle: result box, fallback flag and number of evaluated candidates.
    function automatic void predict(input logic [7:0] start, input int i, input bit dlv,
                                    input int prev, output int b, output bit fbk,
                                    output int evals);
        logic [7:0] v;
        int         span;
        int         cand;
        v    = start;
        span = 1;
        while (span < N_T[i]) span = span * 2;
        for (int k = 1; k <= MT_T[i]; k++) begin
            cand = int'(v) % span;
            if (cand < N_T[i] && (NR_T[i] == 0 || !dlv || cand != prev)) begin
                b = cand; fbk = 1'b0; evals = k;
                return;
            end
            v = lfsr_step(v);
        end
        b     = dlv ? (prev + 1) % N_T[i] : 0;
        fbk   = 1'b1;
        evals = MT_T[i];
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with reset low).
    task automatic do_reset();
        req = 1'b0; enable = 1'b1; reseed = 1'b0; reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || valid_v[i] !== 1'b0 || box_v[i] != 0 || fallback_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got busy=%b valid=%b box=%0d fallback=%b, want all 0",
                         i, busy_v[i], valid_v[i], box_v[i], fallback_v[i]);
            end
        end
        checks++;
        if (u_d0.lfsr_reg !== 8'h01) begin
            errors++; $display("FAIL reset_lfsr: got %h want 01", u_d0.lfsr_reg);
        end
        checks++;
        if (u_d0.cnt_reg !== 8'h00) begin
            errors++; $display("FAIL reset_counter: got %h want 00", u_d0.cnt_reg);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_draw();
        do_reset();
        req = 1'b1; tick(); req = 1'b0;            // cycle 1
        checks++;
        if (busy_v[0] !== 1'b1 || valid_v[0] !== 1'b0) begin
            errors++; $display("FAIL basic_busy c1: got busy=%b valid=%b want 1 0", busy_v[0], valid_v[0]);
        end
        tick();                                     // cycle 2
        checks++;
        if (valid_v[0] !== 1'b1 || box_v[0] != 2 || fallback_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            errors++; $display("FAIL basic_first c2: got valid=%b box=%0d fb=%b busy=%b want 1 2 0 0",
                               valid_v[0], box_v[0], fallback_v[0], busy_v[0]);
        end
        req = 1'b1; tick(); req = 1'b0;            // cycle 3
        checks++;
        if (busy_v[0] !== 1'b1 || valid_v[0] !== 1'b0) begin
            errors++; $display("FAIL basic_b2b_busy c3: got busy=%b valid=%b want 1 0", busy_v[0], valid_v[0]);
        end
        tick();                                     // cycle 4
        checks++;
        if (valid_v[0] !== 1'b1 || box_v[0] != 0 || fallback_v[0] !== 1'b0) begin
            errors++; $display("FAIL basic_second c4: got valid=%b box=%0d fb=%b want 1 0 0",
                               valid_v[0], box_v[0], fallback_v[0]);
        end
        tick();                                     // cycle 5
        checks++;
        if (valid_v[0] !== 1'b0 || box_v[0] != 0) begin
            errors++; $display("FAIL basic_pulse c5: got valid=%b box=%0d want 0 0", valid_v[0], box_v[0]);
        end
        $display("test_basic_draw done");
    endtask

    task automatic test_rejection_fallback();
        do_reset();
        repeat (4) tick();                          // cycle 4
        req = 1'b1; tick(); req = 1'b0;            // cycle 5
        for (int c = 5; c <= 7; c++) begin
            checks++;
            if (busy_v[1] !== 1'b1 || valid_v[1] !== 1'b0) begin
                errors++; $display("FAIL reject_busy c%0d: got busy=%b valid=%b want 1 0", c, busy_v[1], valid_v[1]);
            end
            if (c == 6) begin
                checks++;
                if (valid_v[2] !== 1'b1 || box_v[2] != 0 || fallback_v[2] !== 1'b1) begin
                    errors++; $display("FAIL fallback c6: got valid=%b box=%0d fb=%b want 1 0 1",
                                       valid_v[2], box_v[2], fallback_v[2]);
                end
            end
            tick();
        end
        checks++;                                   // cycle 8
        if (valid_v[1] !== 1'b1 || box_v[1] != 2 || fallback_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
            errors++; $display("FAIL reject_result c8: got valid=%b box=%0d fb=%b busy=%b want 1 2 0 0",
                               valid_v[1], box_v[1], fallback_v[1], busy_v[1]);
        end
        $display("test_rejection_fallback done");
    endtask

    task automatic test_reseed();
        do_reset();
        reseed = 1'b1; tick(); reseed = 1'b0;      // cycle 1
        checks++;
        if (u_d0.lfsr_reg !== 8'h01) begin
            errors++; $display("FAIL reseed_zero c1: got %h want 01", u_d0.lfsr_reg);
        end
        repeat (4) tick();                          // cycle 5
        reseed = 1'b1; tick(); reseed = 1'b0;      // cycle 6
        checks++;
        if (u_d0.lfsr_reg !== 8'h05) begin
            errors++; $display("FAIL reseed_c5 c6: got %h want 05", u_d0.lfsr_reg);
        end
        // Abort a draw in progress.
        do_reset();
        req = 1'b1; tick(); req = 1'b0;            // cycle 1
        reseed = 1'b1; tick(); reseed = 1'b0;      // cycle 2
        checks++;
        if (valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || box_v[0] != 0 || u_d0.lfsr_reg !== 8'h01) begin
            errors++; $display("FAIL reseed_abort c2: got valid=%b busy=%b box=%0d lfsr=%h want 0 0 0 01",
                               valid_v[0], busy_v[0], box_v[0], u_d0.lfsr_reg);
        end
        // reseed and req together in idle: request ignored.
        req = 1'b1; reseed = 1'b1; tick(); req = 1'b0; reseed = 1'b0;  // cycle 3
        checks++;
        if (busy_v[0] !== 1'b0 || u_d0.lfsr_reg !== 8'h02) begin
            errors++; $display("FAIL reseed_req c3: got busy=%b lfsr=%h want 0 02", busy_v[0], u_d0.lfsr_reg);
        end
        $display("test_reseed done");
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) tick();
        req = 1'b1; tick(); req = 1'b0;            // cycle 5
        tick();                                     // cycle 6: one rejection done
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();                                 // cycles 7..9
            checks++;
            if (busy_v[1] !== 1'b1 || valid_v[1] !== 1'b0 || u_d1.tries_reg != 1 || u_d1.lfsr_reg !== 8'h47) begin
                errors++; $display("FAIL stall_frozen k%0d: got busy=%b valid=%b tries=%0d lfsr=%h want 1 0 1 47",
                                   k, busy_v[1], valid_v[1], u_d1.tries_reg, u_d1.lfsr_reg);
            end
        end
        enable = 1'b1;
        tick();                                     // cycle 10
        checks++;
        if (busy_v[1] !== 1'b1 || u_d1.tries_reg != 2) begin
            errors++; $display("FAIL stall_resume c10: got busy=%b tries=%0d want 1 2", busy_v[1], u_d1.tries_reg);
        end
        tick();                                     // cycle 11
        checks++;
        if (valid_v[1] !== 1'b1 || box_v[1] != 2 || fallback_v[1] !== 1'b0) begin
            errors++; $display("FAIL stall_result c11: got valid=%b box=%0d fb=%b want 1 2 0",
                               valid_v[1], box_v[1], fallback_v[1]);
        end
        $display("test_stall done");
    endtask

    task automatic test_reset_mid_draw();
        do_reset();
        repeat (4) tick();
        req = 1'b1; tick(); req = 1'b0;            // cycle 5
        tick();                                     // cycle 6: dut1 busy, dut2 delivered
        reset = 1'b1; tick(); reset = 1'b0;        // cycle 0 again
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || valid_v[i] !== 1'b0 || box_v[i] != 0 || fallback_v[i] !== 1'b0) begin
                errors++; $display("FAIL reset_mid dut%0d: got busy=%b valid=%b box=%0d fb=%b want all 0",
                                   i, busy_v[i], valid_v[i], box_v[i], fallback_v[i]);
            end
        end
        tick();
        checks++;
        if (valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || u_d1.lfsr_reg !== 8'h02) begin
            errors++; $display("FAIL reset_mid_lost: got valid=%b busy=%b lfsr=%h want 0 0 02",
                               valid_v[1], busy_v[1], u_d1.lfsr_reg);
        end
        $display("test_reset_mid_draw done");
    endtask

    // Randomized traffic on all instances, checked every cycle against the
    // transaction model. Runs until max_cyc, or until instances 3 and 4 have
    // each delivered target results (target > 0).
    task automatic run_traffic(input int max_cyc, input int req_pct, input int en_pct,
                               input int rs_pct, input int target,
                               output int n4, output int reps4, output int zeros4);
        bit in_draw [5]; bit need_pred [5]; bit vnow [5]; bit dlv [5]; bit seen [5];
        bit pfb [5];
        int left [5]; int pb [5]; int prev [5]; int last_obs [5]; int ndel [5];
        int cyc;
        n4 = 0; reps4 = 0; zeros4 = 0;
        for (int i = 0; i < 5; i++) begin
            in_draw[i] = 0; need_pred[i] = 0; vnow[i] = 0; dlv[i] = 0; seen[i] = 0;
            pfb[i] = 0; left[i] = 0; pb[i] = 0; prev[i] = 0; last_obs[i] = 0; ndel[i] = 0;
        end
        do_reset();
        cyc = 0;
        while (cyc < max_cyc && !(target > 0 && ndel[3] >= target && ndel[4] >= target)) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (busy_v[i] !== in_draw[i] || valid_v[i] !== vnow[i]) begin
                    errors++; $display("FAIL traffic_handshake dut%0d cyc %0d: got busy=%b valid=%b want %b %b",
                                       i, cyc, busy_v[i], valid_v[i], in_draw[i], vnow[i]);
                end
                if (vnow[i]) begin
                    checks++;
                    if (box_v[i] != pb[i] || fallback_v[i] !== pfb[i]) begin
                        errors++; $display("FAIL traffic_result dut%0d cyc %0d: got box=%0d fb=%b want %0d %b",
                                           i, cyc, box_v[i], fallback_v[i], pb[i], pfb[i]);
                    end
                    if (NR_T[i] == 1 && seen[i]) begin
                        checks++;
                        if (box_v[i] == last_obs[i]) begin
                            errors++; $display("FAIL no_repeat dut%0d cyc %0d: got box=%0d twice, want different",
                                               i, cyc, box_v[i]);
                        end
                    end
                    if (i == 4) begin
                        if (seen[i] && box_v[i] == last_obs[i]) reps4++;
                        if (box_v[i] == 0) zeros4++;
                        n4++;
                    end
                    last_obs[i] = box_v[i];
                    seen[i] = 1;
                    ndel[i]++;
                end
            end
            req    = ($urandom_range(99) < req_pct);
            enable = ($urandom_range(99) < en_pct);
            reseed = ($urandom_range(99) < rs_pct);
            for (int i = 0; i < 5; i++) begin
                vnow[i] = 0;
                if (!in_draw[i]) begin
                    if (req && !reseed) begin
                        in_draw[i] = 1; need_pred[i] = 1;
                    end
                end else begin
                    if (need_pred[i]) begin
                        predict(m_lfsr, i, dlv[i], prev[i], pb[i], pfb[i], left[i]);
                        need_pred[i] = 0;
                    end
                    if (reseed) begin
                        in_draw[i] = 0;
                    end else if (enable) begin
                        left[i]--;
                        if (left[i] == 0) begin
                            in_draw[i] = 0; vnow[i] = 1; dlv[i] = 1; prev[i] = pb[i];
                        end
                    end
                end
            end
            tick();
            cyc++;
        end
        if (target > 0) begin
            checks++;
            if (ndel[3] < target || ndel[4] < target) begin
                errors++; $display("FAIL traffic_timeout: got %0d/%0d draws want %0d each", ndel[3], ndel[4], target);
            end
        end
        req = 1'b0; reseed = 1'b0; enable = 1'b1;
        $display("traffic run: %0d cycles, draws per dut %0d %0d %0d %0d %0d",
                 cyc, ndel[0], ndel[1], ndel[2], ndel[3], ndel[4]);
    endtask

    task automatic test_no_repeat();
        int n, reps, zeros;
        run_traffic(20000, 100, 100, 0, 200, n, reps, zeros);
        checks++;
        if (reps == 0) begin
            errors++; $display("FAIL repeat_allowed: got %0d repeats in %0d draws want > 0", reps, n);
        end
        checks++;
        if (n == 0 || zeros * 100 < n * 35 || zeros * 100 > n * 65) begin
            errors++; $display("FAIL distribution: got %0d zeros of %0d draws want 35..65 percent", zeros, n);
        end
        $display("test_no_repeat done: %0d draws, %0d repeats, %0d zeros", n, reps, zeros);
    endtask

    task automatic test_random_traffic();
        int n, reps, zeros;
        run_traffic(3000, 60, 80, 2, 0, n, reps, zeros);
        $display("test_random_traffic done");
    endtask

    initial begin
        req = 1'b0; enable = 1'b1; reseed = 1'b0; reset = 1'b1;
        test_reset();
        test_basic_draw();
        test_rejection_fallback();
        test_reseed();
        test_stall();
        test_reset_mid_draw();
        test_no_repeat();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
